// File: rtl/pr_ring_router.sv
// rtl/pr_ring_router.sv - ring router node with three input FIFOs and per-output round-robin arbitration
//
// One node of a bidirectional ring. Flits enter from the local CPU (inj),
// from the ccw-side neighbour travelling clockwise (cw_in) or from the
// cw-side neighbour travelling counter-clockwise (ccw_in). Each source is
// buffered in a DEPTH-deep FIFO. Every FIFO head picks an output by
// shortest-path distance to its destination, and each output runs its own
// round-robin arbiter.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   inj_valid/inj_data/inj_ready    local CPU inject channel
//   ej_valid/ej_data/ej_ready       local CPU eject channel
//   cw_in_*  / cw_out_*             clockwise ring channels (in / out)
//   ccw_in_* / ccw_out_*            counter-clockwise ring channels (in / out)
//   almost_full[2:0]                {ccw_in, cw_in, inj} occupancy >= DEPTH-2
//   ej_count[15:0]                  saturating count of ejected flits

module pr_ring_router #(
  parameter int WIDTH     = 31,
  parameter int DEPTH     = 16,
  parameter int NODE_BITS = 2,
  parameter int NODES     = 4,
  parameter int NODE_ID   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inj_valid,
  input  logic [WIDTH-1:0] inj_data,
  output logic             inj_ready,
  output logic             ej_valid,
  output logic [WIDTH-1:0] ej_data,
  input  logic             ej_ready,
  input  logic             cw_in_valid,
  input  logic [WIDTH-1:0] cw_in_data,
  output logic             cw_in_ready,
  output logic             cw_out_valid,
  output logic [WIDTH-1:0] cw_out_data,
  input  logic             cw_out_ready,
  input  logic             ccw_in_valid,
  input  logic [WIDTH-1:0] ccw_in_data,
  output logic             ccw_in_ready,
  output logic             ccw_out_valid,
  output logic [WIDTH-1:0] ccw_out_data,
  input  logic             ccw_out_ready,
  output logic [2:0]       almost_full,
  output logic [15:0]      ej_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]          AF_LVL   = (AW+1)'(DEPTH - 2);
  localparam logic [NODE_BITS-1:0] MY_ID    = NODE_BITS'(NODE_ID);
  localparam logic [NODE_BITS:0]   HALF     = (NODE_BITS+1)'(NODES / 2);

  // Route / grant encodings. NONE means the arbiter has no requester.
  localparam logic [1:0] R_EJ  = 2'd0;
  localparam logic [1:0] R_CW  = 2'd1;
  localparam logic [1:0] R_CCW = 2'd2;
  localparam logic [1:0] NONE  = 2'd3;

  // FIFO index 0 = inj, 1 = cw_in, 2 = ccw_in; this is also the arbiter order.
  logic [2:0]       in_valid;
  logic [WIDTH-1:0] in_data [3];
  logic [WIDTH-1:0] mem     [3][DEPTH];
  logic [AW-1:0]    wr_ptr  [3];
  logic [AW-1:0]    rd_ptr  [3];
  logic [AW:0]      count   [3];
  logic [WIDTH-1:0] head    [3];
  logic [1:0]       route   [3];
  logic [2:0]       full, not_empty, push, pop;
  logic [2:0]       req_ej, req_cw, req_ccw;
  logic [1:0]       g_ej, g_cw, g_ccw;
  logic [1:0]       ptr_ej, ptr_cw, ptr_ccw;
  logic             ej_xfer, cw_xfer, ccw_xfer;

  assign in_valid   = {ccw_in_valid, cw_in_valid, inj_valid};
  assign in_data[0] = inj_data;
  assign in_data[1] = cw_in_data;
  assign in_data[2] = ccw_in_data;

  assign inj_ready    = !full[0];
  assign cw_in_ready  = !full[1];
  assign ccw_in_ready = !full[2];

  // Distance is taken modulo the ring size; the d == NODES/2 tie goes cw.
  function automatic logic [1:0] route_of(input logic [WIDTH-1:0] flit);
    logic [NODE_BITS-1:0] d;
    d = flit[WIDTH-1 -: NODE_BITS] - MY_ID;
    if (d == '0)
      return R_EJ;
    else if ({1'b0, d} <= HALF)
      return R_CW;
    else
      return R_CCW;
  endfunction

  // First requester at or after ptr, wrapping through the three inputs.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = NONE;
    idx  = ptr;
    for (int k = 0; k < 3; k++) begin
      if (pick == NONE && req[idx]) pick = idx;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  function automatic logic [WIDTH-1:0] mux3(input logic [1:0] g, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    case (g)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      full[i]        = (count[i] == FULL_LVL);
      not_empty[i]   = (count[i] != '0);
      push[i]        = in_valid[i] && !full[i];
      almost_full[i] = (count[i] >= AF_LVL);
      head[i]        = mem[i][rd_ptr[i]];
    end
  end

  // Ring traffic keeps its arrival direction even if its destination
  // would suggest turning around.
  always_comb begin
    route[0] = route_of(head[0]);
    route[1] = route_of(head[1]);
    route[2] = route_of(head[2]);
    if (route[1] == R_CCW) route[1] = R_CW;
    if (route[2] == R_CW)  route[2] = R_CCW;
    for (int i = 0; i < 3; i++) begin
      req_ej[i]  = not_empty[i] && (route[i] == R_EJ);
      req_cw[i]  = not_empty[i] && (route[i] == R_CW);
      req_ccw[i] = not_empty[i] && (route[i] == R_CCW);
    end
  end

  always_comb begin
    g_ej          = rr_pick(req_ej, ptr_ej);
    g_cw          = rr_pick(req_cw, ptr_cw);
    g_ccw         = rr_pick(req_ccw, ptr_ccw);
    ej_valid      = (g_ej != NONE);
    cw_out_valid  = (g_cw != NONE);
    ccw_out_valid = (g_ccw != NONE);
    ej_data       = mux3(g_ej, head[0], head[1], head[2]);
    cw_out_data   = mux3(g_cw, head[0], head[1], head[2]);
    ccw_out_data  = mux3(g_ccw, head[0], head[1], head[2]);
    ej_xfer       = ej_valid && ej_ready;
    cw_xfer       = cw_out_valid && cw_out_ready;
    ccw_xfer      = ccw_out_valid && ccw_out_ready;
    for (int i = 0; i < 3; i++) begin
      pop[i] = (ej_xfer && g_ej == 2'(i)) ||
               (cw_xfer && g_cw == 2'(i)) ||
               (ccw_xfer && g_ccw == 2'(i));
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ptr_ej   <= 2'd0;
      ptr_cw   <= 2'd0;
      ptr_ccw  <= 2'd0;
      ej_count <= 16'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + (AW+1)'(1);
          2'b01:   count[i] <= count[i] - (AW+1)'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (ej_xfer)  ptr_ej  <= rr_next(g_ej);
      if (cw_xfer)  ptr_cw  <= rr_next(g_cw);
      if (ccw_xfer) ptr_ccw <= rr_next(g_ccw);
      if (ej_xfer && ej_count != 16'hFFFF) ej_count <= ej_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pr_ring_router.sv
// tb/tb_pr_ring_router.sv - directed checks for pr_ring_router at NODES=4, NODE_ID=1

module tb_pr_ring_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inj_valid = 1'b0, cw_in_valid = 1'b0, ccw_in_valid = 1'b0;
  logic [30:0] inj_data = '0, cw_in_data = '0, ccw_in_data = '0;
  logic        inj_ready, cw_in_ready, ccw_in_ready;
  logic        ej_valid, cw_out_valid, ccw_out_valid;
  logic [30:0] ej_data, cw_out_data, ccw_out_data;
  logic        ej_ready = 1'b1, cw_out_ready = 1'b1, ccw_out_ready = 1'b1;
  logic [2:0]  almost_full;
  logic [15:0] ej_count;

  int checks = 0;
  int failures = 0;

  pr_ring_router #(.WIDTH(31), .DEPTH(16), .NODE_BITS(2), .NODES(4), .NODE_ID(1)) dut (
    .clk(clk), .reset(reset),
    .inj_valid(inj_valid), .inj_data(inj_data), .inj_ready(inj_ready),
    .ej_valid(ej_valid), .ej_data(ej_data), .ej_ready(ej_ready),
    .cw_in_valid(cw_in_valid), .cw_in_data(cw_in_data), .cw_in_ready(cw_in_ready),
    .cw_out_valid(cw_out_valid), .cw_out_data(cw_out_data), .cw_out_ready(cw_out_ready),
    .ccw_in_valid(ccw_in_valid), .ccw_in_data(ccw_in_data), .ccw_in_ready(ccw_in_ready),
    .ccw_out_valid(ccw_out_valid), .ccw_out_data(ccw_out_data), .ccw_out_ready(ccw_out_ready),
    .almost_full(almost_full), .ej_count(ej_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] mk(input logic [1:0] d, input int p);
    logic [28:0] pl;
    pl = p[28:0];
    return {d, pl};
  endfunction

  task automatic drive(input int src, input logic v, input logic [30:0] d);
    case (src)
      0: begin inj_valid = v;    inj_data = d;    end
      1: begin cw_in_valid = v;  cw_in_data = d;  end
      default: begin ccw_in_valid = v; ccw_in_data = d; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int         src;       // 0 inj, 1 cw_in, 2 ccw_in
    logic [1:0] dest;
    int         payload;
    int         port;      // 0 ej, 1 cw_out, 2 ccw_out
  } vec_t;

  vec_t vecs[10];
  logic [30:0] exp_q[$];
  int ej_model;
  int xfers;
  int j;
  logic xfer_now;
  logic [2:0] vmask;

  initial begin
    // Routing vectors, NODE_ID=1: d = dest-1 mod 4.
    vecs[0] = '{0, 2'd1, 'h11, 0};
    vecs[1] = '{0, 2'd2, 'h22, 1};
    vecs[2] = '{0, 2'd3, 'h33, 1};   // d=2 tie goes cw
    vecs[3] = '{0, 2'd0, 'h44, 2};
    vecs[4] = '{1, 2'd1, 'h55, 0};
    vecs[5] = '{1, 2'd0, 'h66, 1};   // cw traffic never turns ccw
    vecs[6] = '{2, 2'd2, 'h77, 2};   // ccw traffic never turns cw
    vecs[7] = '{2, 2'd1, 'h88, 0};
    vecs[8] = '{2, 2'd0, 'h99, 2};
    vecs[9] = '{1, 2'd2, 'hAA, 1};

    // Reset state
    #1;
    chk("rst_valids", {ej_valid, cw_out_valid, ccw_out_valid}, 3'b000);
    chk("rst_readys", {inj_ready, cw_in_ready, ccw_in_ready}, 3'b111);
    chk("rst_af", almost_full, 3'b000);
    chk("rst_count", ej_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Routing table
    ej_model = 0;
    foreach (vecs[k]) begin
      drive(vecs[k].src, 1'b1, mk(vecs[k].dest, vecs[k].payload));
      #1;
      chk($sformatf("rt%0d_ready", k),
          (vecs[k].src == 0) ? inj_ready : (vecs[k].src == 1) ? cw_in_ready : ccw_in_ready, 1'b1);
      @(negedge clk);
      drive(vecs[k].src, 1'b0, '0);
      vmask = 3'b000;
      vmask[vecs[k].port] = 1'b1;
      chk($sformatf("rt%0d_valids", k), {ccw_out_valid, cw_out_valid, ej_valid}, vmask);
      chk($sformatf("rt%0d_data", k),
          (vecs[k].port == 0) ? ej_data : (vecs[k].port == 1) ? cw_out_data : ccw_out_data,
          mk(vecs[k].dest, vecs[k].payload));
      if (vecs[k].port == 0) ej_model++;
      @(negedge clk);
      chk($sformatf("rt%0d_gone", k), {ccw_out_valid, cw_out_valid, ej_valid}, 3'b000);
    end
    chk("rt_ej_count", ej_count, 16'(ej_model));

    // Backpressure: fill cw_in while cw_out is stalled
    cw_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1'b1, mk(2'd3, 'h300 + i));
      @(negedge clk);
      chk($sformatf("bp_af_%0d", i + 1), almost_full[1], (i + 1) >= 14);
      chk($sformatf("bp_ready_%0d", i + 1), cw_in_ready, (i + 1) < 16);
    end
    drive(1, 1'b1, mk(2'd3, 'h3FF));   // offered while full, must not enter
    @(negedge clk);
    drive(1, 1'b0, '0);
    chk("bp_stall_valid", cw_out_valid, 1'b1);
    cw_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp_drain_v%0d", i), cw_out_valid, 1'b1);
      chk($sformatf("bp_drain_d%0d", i), cw_out_data, mk(2'd3, 'h300 + i));
      @(negedge clk);
    end
    chk("bp_empty", cw_out_valid, 1'b0);
    chk("bp_af_clear", almost_full, 3'b000);

    // Reset mid-stream with 5 flits buffered
    cw_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, mk(2'd2, 'h500 + i));
      @(negedge clk);
    end
    drive(1, 1'b0, '0);
    chk("mr_pre_valid", cw_out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mr_valids", {ej_valid, cw_out_valid, ccw_out_valid}, 3'b000);
    chk("mr_readys", {inj_ready, cw_in_ready, ccw_in_ready}, 3'b111);
    chk("mr_af", almost_full, 3'b000);
    chk("mr_count", ej_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    cw_out_ready = 1'b1;
    drive(0, 1'b1, mk(2'd2, 'h5A));
    @(negedge clk);
    drive(0, 1'b0, '0);
    chk("mr_new_valid", cw_out_valid, 1'b1);
    chk("mr_new_data", cw_out_data, mk(2'd2, 'h5A));
    @(negedge clk);
    chk("mr_no_stale", cw_out_valid, 1'b0);

    // Contention on cw_out: preload 6 flits each from inj and cw_in
    do_reset();
    cw_out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, mk(2'd2, 'h100 + i));
      drive(1, 1'b1, mk(2'd2, 'h200 + i));
      exp_q.push_back(mk(2'd2, 'h100 + i));
      exp_q.push_back(mk(2'd2, 'h200 + i));
      @(negedge clk);
    end
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    j = 0;
    for (int c = 0; c < 40 && j < 12; c++) begin
      cw_out_ready = (c < 4) ? 1'b1 : c[0];
      #1;
      chk($sformatf("ct_v%0d", c), cw_out_valid, 1'b1);
      chk($sformatf("ct_d%0d", c), cw_out_data, exp_q[j]);
      if (cw_out_ready) j++;
      @(negedge clk);
    end
    chk("ct_all_out", j, 12);
    cw_out_ready = 1'b1;
    chk("ct_empty", cw_out_valid, 1'b0);

    // Three-way eject
    do_reset();
    drive(0, 1'b1, mk(2'd1, 'hA1));
    drive(1, 1'b1, mk(2'd1, 'hB2));
    drive(2, 1'b1, mk(2'd1, 'hC3));
    @(negedge clk);
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    chk("ej3_d0", {ej_valid, ej_data}, {1'b1, mk(2'd1, 'hA1)});
    @(negedge clk);
    chk("ej3_d1", {ej_valid, ej_data}, {1'b1, mk(2'd1, 'hB2)});
    @(negedge clk);
    chk("ej3_d2", {ej_valid, ej_data}, {1'b1, mk(2'd1, 'hC3)});
    @(negedge clk);
    chk("ej3_done", ej_valid, 1'b0);
    chk("ej3_count", ej_count, 16'd3);

    // Saturation: 65537 back-to-back eject transfers
    do_reset();
    drive(0, 1'b1, mk(2'd1, 'h7));
    xfers = 0;
    for (int c = 0; c < 70000 && xfers < 65537; c++) begin
      xfer_now = ej_valid && ej_ready;
      @(negedge clk);
      if (xfer_now) begin
        xfers++;
        if (xfers == 65534) chk("sat_fffe", ej_count, 16'hFFFE);
        if (xfers == 65535) chk("sat_ffff", ej_count, 16'hFFFF);
      end
    end
    drive(0, 1'b0, '0);
    chk("sat_xfers", xfers, 65537);
    chk("sat_hold", ej_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
